// File: rtl/lbist_tpg.sv
// LFSR test pattern generator: emits a programmable-length burst of pseudo-random
// words over a valid/ready handshake and raises a sticky done flag when the burst completes.
module lbist_tpg #(
  parameter int              BITS    = 4,
  parameter logic [0:BITS-1] TAPS    = 4'b0011,
  parameter int              NUM_PAT = 15,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [0:BITS-1]  seed,
  input  logic             pat_ready,
  output logic [0:BITS-1]  pat,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r;
  logic   xfer_s;

  // Fibonacci step: tapped bits fold into q[0], everything else shifts toward BITS-1.
  function automatic logic [0:BITS-1] lfsr_next(input logic [0:BITS-1] cur);
    logic fb;
    fb = ^(cur & TAPS);
    return {fb, cur[0:BITS-2]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by a single set bit.
  function automatic logic [0:BITS-1] seed_load(input logic [0:BITS-1] s);
    logic [0:BITS-1] v;
    if (s == {BITS{1'b0}}) begin
      v          = {BITS{1'b0}};
      v[BITS-1]  = 1'b1;
    end else begin
      v = s;
    end
    return v;
  endfunction

  // Handshake completion on the registered valid.
  always_comb begin
    xfer_s = 1'b0;
    if (pat_valid && pat_ready) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Burst control FSM; pat itself is the LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pat       <= {BITS{1'b0}};
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_cnt   <= {CNT_W{1'b0}};
    end else if (abort) begin
      // A transfer landing in the abort cycle still counts.
      if (xfer_s) begin
        pat_cnt <= pat_cnt + CNT_W'(1);
        pat     <= lfsr_next(pat);
      end
      state_r   <= IDLE;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            pat       <= seed_load(seed);
            pat_cnt   <= {CNT_W{1'b0}};
            done      <= 1'b0;
            busy      <= 1'b1;
            pat_valid <= 1'b1;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (xfer_s) begin
            pat_cnt <= pat_cnt + CNT_W'(1);
            pat     <= lfsr_next(pat);
            if (pat_cnt == CNT_W'(NUM_PAT - 1)) begin
              state_r   <= DONE;
              pat_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          pat_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
